// File: rtl/ex_unit_pkg.sv
// Shared op-code and width definitions for the reservation station, decoder and execute unit.
package ex_unit_pkg;

    localparam int OP_LOG  = 5;
    localparam int ROB_LOG = 4;

    localparam logic [OP_LOG-1:0] OP_ADD   = 5'd0;
    localparam logic [OP_LOG-1:0] OP_SUB   = 5'd1;
    localparam logic [OP_LOG-1:0] OP_AND   = 5'd2;
    localparam logic [OP_LOG-1:0] OP_OR    = 5'd3;
    localparam logic [OP_LOG-1:0] OP_XOR   = 5'd4;
    localparam logic [OP_LOG-1:0] OP_SLL   = 5'd5;
    localparam logic [OP_LOG-1:0] OP_SRL   = 5'd6;
    localparam logic [OP_LOG-1:0] OP_SRA   = 5'd7;
    localparam logic [OP_LOG-1:0] OP_SLT   = 5'd8;
    localparam logic [OP_LOG-1:0] OP_SLTU  = 5'd9;
    localparam logic [OP_LOG-1:0] OP_ADDI  = 5'd10;
    localparam logic [OP_LOG-1:0] OP_ANDI  = 5'd11;
    localparam logic [OP_LOG-1:0] OP_ORI   = 5'd12;
    localparam logic [OP_LOG-1:0] OP_XORI  = 5'd13;
    localparam logic [OP_LOG-1:0] OP_SLLI  = 5'd14;
    localparam logic [OP_LOG-1:0] OP_SRLI  = 5'd15;
    localparam logic [OP_LOG-1:0] OP_SRAI  = 5'd16;
    localparam logic [OP_LOG-1:0] OP_SLTI  = 5'd17;
    localparam logic [OP_LOG-1:0] OP_SLTIU = 5'd18;
    localparam logic [OP_LOG-1:0] OP_LUI   = 5'd19;
    localparam logic [OP_LOG-1:0] OP_AUIPC = 5'd20;
    localparam logic [OP_LOG-1:0] OP_JAL   = 5'd21;
    localparam logic [OP_LOG-1:0] OP_JALR  = 5'd22;
    localparam logic [OP_LOG-1:0] OP_BEQ   = 5'd23;
    localparam logic [OP_LOG-1:0] OP_BNE   = 5'd24;
    localparam logic [OP_LOG-1:0] OP_BLT   = 5'd25;
    localparam logic [OP_LOG-1:0] OP_BGE   = 5'd26;
    localparam logic [OP_LOG-1:0] OP_BLTU  = 5'd27;
    localparam logic [OP_LOG-1:0] OP_BGEU  = 5'd28;

    // I-type ALU ops take the immediate as their second operand.
    function automatic logic uses_imm(input logic [OP_LOG-1:0] op);
        return (op >= OP_ADDI) && (op <= OP_SLTIU);
    endfunction

    function automatic logic is_branch(input logic [OP_LOG-1:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

endpackage

// File: rtl/ex_unit_br_cmp.sv
// Combinational branch condition evaluation on rs1/rs2.
module br_cmp
    import ex_unit_pkg::*;
(
    input  logic [OP_LOG-1:0] op_i,
    input  logic [31:0]       vj_i,
    input  logic [31:0]       vk_i,
    output logic              taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            OP_BEQ:  taken_o = (vj_i == vk_i);
            OP_BNE:  taken_o = (vj_i != vk_i);
            OP_BLT:  taken_o = ($signed(vj_i) <  $signed(vk_i));
            OP_BGE:  taken_o = ($signed(vj_i) >= $signed(vk_i));
            OP_BLTU: taken_o = (vj_i <  vk_i);
            OP_BGEU: taken_o = (vj_i >= vk_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_unit.sv
// Single-cycle integer execute unit: ALU, jumps and branch resolution with a registered CDB broadcast.
module ex_unit
    import ex_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               jump_flag,
    input  logic               FU_enable,
    input  logic [OP_LOG-1:0]  FU_op,
    input  logic [31:0]        FU_Vj,
    input  logic [31:0]        FU_Vk,
    input  logic [31:0]        FU_Imm,
    input  logic [31:0]        FU_CurPC,
    input  logic [ROB_LOG-1:0] FU_DestRob,
    output logic               exc_valid,
    output logic [ROB_LOG-1:0] exc_RobId,
    output logic [31:0]        exc_value,
    output logic               exc_jump,
    output logic [31:0]        exc_target
);

    logic               valid_q;
    logic [ROB_LOG-1:0] rob_q;
    logic [31:0]        value_q, value_d;
    logic               jump_q, jump_d;
    logic [31:0]        target_q, target_d;

    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [31:0] pc_plus4;
    logic [31:0] pc_imm;
    logic        br_taken;
    logic        accept;

    br_cmp u_br_cmp (
        .op_i    (FU_op),
        .vj_i    (FU_Vj),
        .vk_i    (FU_Vk),
        .taken_o (br_taken)
    );

    assign accept = rdy && FU_enable && !jump_flag;

    always_comb begin
        op2      = uses_imm(FU_op) ? FU_Imm : FU_Vk;
        shamt    = op2[4:0];
        pc_plus4 = FU_CurPC + 32'd4;
        pc_imm   = FU_CurPC + FU_Imm;
        value_d  = FU_Vj + FU_Vk;
        jump_d   = 1'b0;
        target_d = pc_plus4;
        case (FU_op)
            OP_ADD, OP_ADDI:   value_d = FU_Vj + op2;
            OP_SUB:            value_d = FU_Vj - FU_Vk;
            OP_AND, OP_ANDI:   value_d = FU_Vj & op2;
            OP_OR, OP_ORI:     value_d = FU_Vj | op2;
            OP_XOR, OP_XORI:   value_d = FU_Vj ^ op2;
            OP_SLL, OP_SLLI:   value_d = FU_Vj << shamt;
            OP_SRL, OP_SRLI:   value_d = FU_Vj >> shamt;
            OP_SRA, OP_SRAI:   value_d = $unsigned($signed(FU_Vj) >>> shamt);
            OP_SLT, OP_SLTI:   value_d = {31'd0, $signed(FU_Vj) < $signed(op2)};
            OP_SLTU, OP_SLTIU: value_d = {31'd0, FU_Vj < op2};
            OP_LUI:            value_d = FU_Imm;
            OP_AUIPC:          value_d = pc_imm;
            OP_JAL: begin
                value_d  = pc_plus4;
                jump_d   = 1'b1;
                target_d = pc_imm;
            end
            OP_JALR: begin
                value_d  = pc_plus4;
                jump_d   = 1'b1;
                target_d = (FU_Vj + FU_Imm) & 32'hFFFF_FFFE;
            end
            default: begin
                // Branches land here too; anything else undefined behaves as ADD.
                if (is_branch(FU_op)) begin
                    value_d  = 32'd0;
                    jump_d   = br_taken;
                    target_d = br_taken ? pc_imm : pc_plus4;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            rob_q    <= '0;
            value_q  <= 32'd0;
            jump_q   <= 1'b0;
            target_q <= 32'd0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            rob_q    <= FU_DestRob;
            value_q  <= value_d;
            jump_q   <= jump_d;
            target_q <= target_d;
        end else begin
            valid_q  <= 1'b0;
        end
    end

    assign exc_valid  = valid_q;
    assign exc_RobId  = rob_q;
    assign exc_value  = value_q;
    assign exc_jump   = jump_q;
    assign exc_target = target_q;

endmodule

// File: tb/tb_ex_unit.sv
// Directed self-checking bench for ex_unit with hand-computed expectations.
module tb_ex_unit;
    import ex_unit_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               rdy;
    logic               jump_flag;
    logic               FU_enable;
    logic [OP_LOG-1:0]  FU_op;
    logic [31:0]        FU_Vj, FU_Vk, FU_Imm, FU_CurPC;
    logic [ROB_LOG-1:0] FU_DestRob;
    logic               exc_valid;
    logic [ROB_LOG-1:0] exc_RobId;
    logic [31:0]        exc_value;
    logic               exc_jump;
    logic [31:0]        exc_target;

    int compared = 0;
    int mismatched = 0;

    ex_unit dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .jump_flag  (jump_flag),
        .FU_enable  (FU_enable),
        .FU_op      (FU_op),
        .FU_Vj      (FU_Vj),
        .FU_Vk      (FU_Vk),
        .FU_Imm     (FU_Imm),
        .FU_CurPC   (FU_CurPC),
        .FU_DestRob (FU_DestRob),
        .exc_valid  (exc_valid),
        .exc_RobId  (exc_RobId),
        .exc_value  (exc_value),
        .exc_jump   (exc_jump),
        .exc_target (exc_target)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [OP_LOG-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [ROB_LOG-1:0] tag);
        FU_enable  = 1'b1;
        FU_op      = op;
        FU_Vj      = vj;
        FU_Vk      = vk;
        FU_Imm     = imm;
        FU_CurPC   = pc;
        FU_DestRob = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; jump_flag = 1'b0;
        drive(OP_ADD, 32'd7, 32'd9, 32'd0, 32'h80, 4'd3);
        tick(); tick();
        compared++; if (exc_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %h want 0", exc_valid); end
        compared++; if (exc_RobId !== 4'd0) begin mismatched++; $display("FAIL reset_rob got %h want 0", exc_RobId); end
        compared++; if (exc_value !== 32'd0) begin mismatched++; $display("FAIL reset_value got %h want 0", exc_value); end
        compared++; if (exc_jump !== 1'b0) begin mismatched++; $display("FAIL reset_jump got %h want 0", exc_jump); end
        compared++; if (exc_target !== 32'd0) begin mismatched++; $display("FAIL reset_target got %h want 0", exc_target); end
        rst = 1'b0;
        FU_enable = 1'b0;
        tick();
        compared++; if (exc_valid !== 1'b0) begin mismatched++; $display("FAIL post_reset_idle_valid got %h want 0", exc_valid); end
    endtask

    task automatic test_alu();
        drive(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h10, 4'd5);
        tick();
        compared++; if (exc_valid !== 1'b1) begin mismatched++; $display("FAIL add_valid got %h want 1", exc_valid); end
        compared++; if (exc_value !== 32'd0) begin mismatched++; $display("FAIL add_value got %h want 0", exc_value); end
        compared++; if (exc_RobId !== 4'd5) begin mismatched++; $display("FAIL add_rob got %h want 5", exc_RobId); end
        compared++; if (exc_jump !== 1'b0) begin mismatched++; $display("FAIL add_jump got %h want 0", exc_jump); end
        compared++; if (exc_target !== 32'h14) begin mismatched++; $display("FAIL add_target got %h want 14", exc_target); end
        drive(OP_SUB, 32'd5, 32'd7, 32'd100, 32'h0, 4'd6);
        tick();
        compared++; if (exc_value !== 32'hFFFF_FFFE) begin mismatched++; $display("FAIL sub_value got %h want fffffffe", exc_value); end
        drive(OP_ANDI, 32'h0000_F0F0, 32'h0, 32'h0000_00FF, 32'h0, 4'd7);
        tick();
        compared++; if (exc_value !== 32'h0000_00F0) begin mismatched++; $display("FAIL andi_value got %h want f0", exc_value); end
        drive(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h1234, 32'h0, 4'd8);
        tick();
        compared++; if (exc_value !== 32'h5555_5555) begin mismatched++; $display("FAIL xor_value got %h want 55555555", exc_value); end
        drive(OP_ORI, 32'h0000_0F00, 32'hFFFF_FFFF, 32'h0000_000F, 32'h0, 4'd9);
        tick();
        compared++; if (exc_value !== 32'h0000_0F0F) begin mismatched++; $display("FAIL ori_value got %h want f0f", exc_value); end
        drive(OP_LUI, 32'h1, 32'h2, 32'h1234_5000, 32'h0, 4'd10);
        tick();
        compared++; if (exc_value !== 32'h1234_5000) begin mismatched++; $display("FAIL lui_value got %h want 12345000", exc_value); end
        drive(OP_AUIPC, 32'h1, 32'h2, 32'h0000_0020, 32'h1000, 4'd11);
        tick();
        compared++; if (exc_value !== 32'h0000_1020) begin mismatched++; $display("FAIL auipc_value got %h want 1020", exc_value); end
        compared++; if (exc_target !== 32'h0000_1004) begin mismatched++; $display("FAIL auipc_target got %h want 1004", exc_target); end
        drive(5'd31, 32'd2, 32'd3, 32'd100, 32'h50, 4'd12);
        tick();
        compared++; if (exc_value !== 32'd5) begin mismatched++; $display("FAIL undef_value got %h want 5", exc_value); end
        compared++; if (exc_jump !== 1'b0) begin mismatched++; $display("FAIL undef_jump got %h want 0", exc_jump); end
        compared++; if (exc_target !== 32'h54) begin mismatched++; $display("FAIL undef_target got %h want 54", exc_target); end
    endtask

    task automatic test_shift_slt();
        drive(OP_SRA, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 4'd1);
        tick();
        compared++; if (exc_value !== 32'hC000_0000) begin mismatched++; $display("FAIL sra_value got %h want c0000000", exc_value); end
        drive(OP_SRL, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 4'd2);
        tick();
        compared++; if (exc_value !== 32'h4000_0000) begin mismatched++; $display("FAIL srl_value got %h want 40000000", exc_value); end
        drive(OP_SLLI, 32'h1, 32'h0, 32'h24, 32'h0, 4'd3);
        tick();
        compared++; if (exc_value !== 32'h10) begin mismatched++; $display("FAIL slli_value got %h want 10", exc_value); end
        drive(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'd4);
        tick();
        compared++; if (exc_value !== 32'd1) begin mismatched++; $display("FAIL sltu_value got %h want 1", exc_value); end
        drive(OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'd5);
        tick();
        compared++; if (exc_value !== 32'd0) begin mismatched++; $display("FAIL slt_value got %h want 0", exc_value); end
        drive(OP_SLTIU, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h0, 4'd6);
        tick();
        compared++; if (exc_value !== 32'd1) begin mismatched++; $display("FAIL sltiu_value got %h want 1", exc_value); end
    endtask

    task automatic test_jumps();
        drive(OP_JALR, 32'h203, 32'h0, 32'h0, 32'h100, 4'd7);
        tick();
        compared++; if (exc_value !== 32'h104) begin mismatched++; $display("FAIL jalr_value got %h want 104", exc_value); end
        compared++; if (exc_jump !== 1'b1) begin mismatched++; $display("FAIL jalr_jump got %h want 1", exc_jump); end
        compared++; if (exc_target !== 32'h202) begin mismatched++; $display("FAIL jalr_target got %h want 202", exc_target); end
        drive(OP_JAL, 32'h0, 32'h0, 32'h10, 32'h200, 4'd8);
        tick();
        compared++; if (exc_value !== 32'h204) begin mismatched++; $display("FAIL jal_value got %h want 204", exc_value); end
        compared++; if (exc_target !== 32'h210) begin mismatched++; $display("FAIL jal_target got %h want 210", exc_target); end
    endtask

    task automatic test_branch();
        drive(OP_BLT, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF8, 32'h40, 4'd9);
        tick();
        compared++; if (exc_jump !== 1'b1) begin mismatched++; $display("FAIL blt_jump got %h want 1", exc_jump); end
        compared++; if (exc_target !== 32'h38) begin mismatched++; $display("FAIL blt_target got %h want 38", exc_target); end
        compared++; if (exc_value !== 32'h0) begin mismatched++; $display("FAIL blt_value got %h want 0", exc_value); end
        drive(OP_BLTU, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF8, 32'h40, 4'd10);
        tick();
        compared++; if (exc_jump !== 1'b0) begin mismatched++; $display("FAIL bltu_jump got %h want 0", exc_jump); end
        compared++; if (exc_target !== 32'h44) begin mismatched++; $display("FAIL bltu_target got %h want 44", exc_target); end
        drive(OP_BEQ, 32'd3, 32'd3, 32'h100, 32'h80, 4'd11);
        tick();
        compared++; if (exc_jump !== 1'b1 || exc_target !== 32'h180) begin mismatched++; $display("FAIL beq_taken got %h/%h want 1/180", exc_jump, exc_target); end
        drive(OP_BGE, 32'hFFFF_FFFF, 32'd0, 32'h100, 32'h80, 4'd12);
        tick();
        compared++; if (exc_jump !== 1'b0 || exc_target !== 32'h84) begin mismatched++; $display("FAIL bge_nt got %h/%h want 0/84", exc_jump, exc_target); end
        drive(OP_BGEU, 32'hFFFF_FFFF, 32'd0, 32'h100, 32'h80, 4'd13);
        tick();
        compared++; if (exc_jump !== 1'b1 || exc_target !== 32'h180) begin mismatched++; $display("FAIL bgeu_taken got %h/%h want 1/180", exc_jump, exc_target); end
        drive(OP_BNE, 32'd4, 32'd4, 32'h100, 32'h80, 4'd14);
        tick();
        compared++; if (exc_jump !== 1'b0 || exc_target !== 32'h84) begin mismatched++; $display("FAIL bne_nt got %h/%h want 0/84", exc_jump, exc_target); end
    endtask

    task automatic test_back_to_back();
        int bcasts = 0;
        drive(OP_ADDI, 32'd10, 32'd0, 32'd1, 32'h0, 4'd1);
        tick();
        if (exc_valid === 1'b1) bcasts++;
        compared++; if (exc_valid !== 1'b1 || exc_RobId !== 4'd1 || exc_value !== 32'd11) begin mismatched++; $display("FAIL b2b_first got v%h tag%h val%h want v1 tag1 val0b", exc_valid, exc_RobId, exc_value); end
        rdy = 1'b0;
        drive(OP_ADDI, 32'd20, 32'd0, 32'd2, 32'h0, 4'd2);
        tick();
        if (exc_valid === 1'b1) bcasts++;
        compared++; if (exc_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_gap_valid got %h want 0", exc_valid); end
        compared++; if (exc_RobId !== 4'd1 || exc_value !== 32'd11) begin mismatched++; $display("FAIL b2b_gap_hold got tag%h val%h want tag1 val0b", exc_RobId, exc_value); end
        rdy = 1'b1;
        drive(OP_ADDI, 32'd30, 32'd0, 32'd3, 32'h0, 4'd3);
        tick();
        if (exc_valid === 1'b1) bcasts++;
        compared++; if (exc_valid !== 1'b1 || exc_RobId !== 4'd3 || exc_value !== 32'd33) begin mismatched++; $display("FAIL b2b_third got v%h tag%h val%h want v1 tag3 val21", exc_valid, exc_RobId, exc_value); end
        FU_enable = 1'b0;
        tick();
        if (exc_valid === 1'b1) bcasts++;
        compared++; if (bcasts !== 2) begin mismatched++; $display("FAIL b2b_count got %0d want 2", bcasts); end
    endtask

    task automatic test_flush_reset();
        drive(OP_ADD, 32'd1, 32'd2, 32'h0, 32'h0, 4'd4);
        tick();
        jump_flag = 1'b1;
        drive(OP_ADD, 32'd5, 32'd5, 32'h0, 32'h0, 4'd9);
        tick();
        compared++; if (exc_valid !== 1'b0) begin mismatched++; $display("FAIL flush_valid got %h want 0", exc_valid); end
        compared++; if (exc_RobId !== 4'd4 || exc_value !== 32'd3) begin mismatched++; $display("FAIL flush_hold got tag%h val%h want tag4 val3", exc_RobId, exc_value); end
        jump_flag = 1'b0;
        drive(OP_JAL, 32'd0, 32'd0, 32'h40, 32'h300, 4'd6);
        tick();
        rst = 1'b1;
        drive(OP_ADD, 32'd7, 32'd7, 32'h0, 32'h0, 4'd7);
        tick();
        compared++; if (exc_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mid_valid got %h want 0", exc_valid); end
        compared++; if (exc_RobId !== 4'd0 || exc_value !== 32'd0 || exc_jump !== 1'b0 || exc_target !== 32'd0) begin mismatched++; $display("FAIL rst_mid_zero got tag%h val%h j%h tgt%h want all 0", exc_RobId, exc_value, exc_jump, exc_target); end
        rst = 1'b0;
        FU_enable = 1'b0;
        tick();
        compared++; if (exc_valid !== 1'b0) begin mismatched++; $display("FAIL rst_no_stale got %h want 0", exc_valid); end
        drive(OP_ADD, 32'd8, 32'd1, 32'h0, 32'h0, 4'd15);
        tick();
        compared++; if (exc_valid !== 1'b1 || exc_RobId !== 4'd15 || exc_value !== 32'd9) begin mismatched++; $display("FAIL rst_redispatch got v%h tag%h val%h want v1 tagf val9", exc_valid, exc_RobId, exc_value); end
        FU_enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_shift_slt();
        test_jumps();
        test_branch();
        test_back_to_back();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ex_unit.md
EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 SHALL have clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have rdy  input  1  global ready; low = freeze cycle.
REQ-004 SHALL have jump_flag  input  1  pipeline flush (mispredict recovery).
REQ-005 SHALL have FU_enable  input  1  dispatch valid from reservation station; no backpressure.
REQ-006 SHALL have FU_op  input  OP_LOG  decoded operation.
REQ-007 SHALL have FU_Vj, FU_Vk, FU_Imm, FU_CurPC  input  32 each  rs1 value, rs2 value, immediate, instruction PC.
REQ-008 SHALL have FU_DestRob  input  ROB_LOG  destination ROB tag.
REQ-009 SHALL have exc_valid  output  1  result broadcast valid (CDB).
REQ-010 SHALL have exc_RobId  output  ROB_LOG  tag of broadcast result.
REQ-011 SHALL have exc_value  output  32  rd value (link value for JAL/JALR).
REQ-012 SHALL have exc_jump  output  1  control transfer taken (branch taken, JAL, JALR).
REQ-013 SHALL have exc_target  output  32  resolved next PC.

Function
REQ-014 SHALL accept one operation on every rising edge where rdy=1, FU_enable=1, rst=0, jump_flag=0; no ready/busy output exists.
REQ-015 SHALL register all outputs; op sampled at edge N drives exc_* during cycle N+1 (latency 1).
REQ-016 SHALL deassert exc_valid on the edge following any cycle with FU_enable=0, rdy=0, or jump_flag=1; other exc_* hold last values.
REQ-017 SHALL compute ALU ops mod 2^32: ADD/ADDI, SUB, AND/ANDI, OR/ORI, XOR/XORI; second operand = FU_Vk for R-type, FU_Imm for I-type.
REQ-018 SHALL shift by operand[4:0] only: SLL/SLLI, SRL/SRLI logical, SRA/SRAI arithmetic (sign fill).
REQ-019 SHALL compute SLT/SLTI signed, SLTU/SLTIU unsigned, result 0 or 1 zero-extended.
REQ-020 SHALL produce LUI = FU_Imm; AUIPC = FU_CurPC + FU_Imm.
REQ-021 SHALL produce for JAL: value = CurPC+4, jump=1, target = CurPC+Imm.
REQ-022 SHALL produce for JALR: value = CurPC+4, jump=1, target = (Vj+Imm) with bit 0 cleared.
REQ-023 SHALL evaluate BEQ/BNE/BLT/BGE (signed)/BLTU/BGEU (unsigned) on Vj,Vk; taken: jump=1, target=CurPC+Imm; not taken: jump=0, target=CurPC+4; value = 0.
REQ-024 SHALL drive jump=0, target=CurPC+4 for all non-control ops.
REQ-025 SHALL treat undefined op codes as ADD with jump=0 (no X propagation).
REQ-026 SHALL give jump_flag priority over FU_enable in the same cycle: incoming op discarded, exc_valid=0 next cycle.
REQ-027 SHALL pass FU_DestRob unchanged to exc_RobId; ROB_LOG-bit tag, no wrap logic.

Reset
REQ-028 SHALL, when rst=1 at an edge, set exc_valid=0, exc_jump=0, exc_RobId=0, exc_value=0, exc_target=0, regardless of rdy or FU_enable.
REQ-029 SHALL, on reset mid-operation, drop any sampled-but-unbroadcast result; first valid broadcast only after a post-reset dispatch.

Structure
REQ-030 SHALL take OP_LOG, ROB_LOG and all op-code constants from the shared config header used by the reservation station and decoder; no local redefinitions.
REQ-031 SHALL be one module; a combinational branch-compare sub-module br_cmp (op, Vj, Vk -> taken) is permitted.

Verification
REQ-032 SHALL test ADD Vj=0xFFFFFFFF, Vk=1, tag 5 -> next cycle exc_valid=1, value=0, RobId=5, jump=0.
REQ-033 SHALL test SRA Vj=0x80000000, Vk=0x21 -> value=0xC0000000; SLTU Vj=1, Vk=0xFFFFFFFF -> 1; SLT same -> 0.
REQ-034 SHALL test JALR CurPC=0x100, Vj=0x203, Imm=0 -> value=0x104, jump=1, target=0x202.
REQ-035 SHALL test BLT Vj=-1, Vk=0, CurPC=0x40, Imm=-8 -> jump=1, target=0x38; BLTU same operands -> jump=0, target=0x44.
REQ-036 SHALL test back-to-back dispatch on 3 consecutive edges with rdy low on the 2nd -> exactly 2 broadcasts with correct tags, gap cycle exc_valid=0.
REQ-037 SHALL test FU_enable=1 with jump_flag=1, then rst=1 with FU_enable=1 -> exc_valid=0 after each; all outputs 0 after reset.
